// File: rtl/snake_pkg.sv
// Shared definitions for the snake game control slice.
//   - collision codes produced by the collision detector
//   - game-state encoding (also driven out on the state port)
//   - default score counter width
package snake_pkg;

  localparam logic [1:0] NO_COLLISION    = 2'b00;
  localparam logic [1:0] APPLE_COLLISION = 2'b01;
  localparam logic [1:0] WALL_COLLISION  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_RESPAWN = 2'b10,
    ST_OVER    = 2'b11
  } game_state_t;

  localparam int DEFAULT_SCORE_W = 8;

endpackage

// File: rtl/snake_edge_det.sv
// 1-bit rising-edge detector.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (clears the history bit)
//   din   - level input
//   rise  - din & ~(din one cycle ago); combinational from the live input
module snake_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_reg <= 1'b0;
    else        d_reg <= din;
  end

  assign rise = din & ~d_reg;

endmodule

// File: rtl/snake_game_ctrl.sv
// Game-level controller for the snake game.
// Consumes the collision code, runs the IDLE/RUN/RESPAWN/OVER FSM, gates
// movement, issues grow/clear pulses, handshakes apple re-placement and keeps
// score and speed level. All outputs are registered.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start             - start/restart button (level, debounced)
//   tick              - one-cycle movement tick
//   collision[1:0]    - 00 none, 01 apple, 1x wall/self
//   apple_ack         - spawner placed a new apple (pulse)
//   move_en           - snake may advance (tick delayed one cycle)
//   grow              - one-cycle lengthen pulse
//   apple_req         - level request for a new apple, held until ack
//   clear             - one-cycle pulse re-initialising detector and body
//   game_over         - high in OVER
//   state[1:0]        - current game state
//   score[SCORE_W-1:0]- apples eaten this game (saturating)
//   speed[1:0]        - speed level (saturating at SPEED_MAX)
//   hi_score          - only with SNAKE_HISCORE_EN: best score since reset
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int SCORE_W       = DEFAULT_SCORE_W,
  parameter int SPEEDUP_EVERY = 4,
  parameter int SPEED_MAX     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               tick,
  input  logic [1:0]         collision,
  input  logic               apple_ack,
  output logic               move_en,
  output logic               grow,
  output logic               apple_req,
  output logic               clear,
  output logic               game_over,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         speed
`ifdef SNAKE_HISCORE_EN
  ,
  output logic [SCORE_W-1:0] hi_score
`endif
);

  localparam int                 CNT_W     = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SPEEDUP_EVERY - 1);
  localparam logic [1:0]         SPEED_TOP = 2'(SPEED_MAX);
  localparam logic [SCORE_W-1:0] SCORE_TOP = '1;

  game_state_t      state_reg;
  logic [CNT_W-1:0] apple_cnt_reg;

  // Bit 0: start button, bit 1: "collision is apple". Only rising edges
  // matter: the detector holds 01 for the whole overlap.
  logic [1:0] edge_in;
  logic [1:0] edge_rise;
  logic       start_rise;
  logic       apple_hit;
  logic       wall_hit;

  assign edge_in = {collision == APPLE_COLLISION, start};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
      snake_edge_det u_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (edge_in[gi]),
        .rise (edge_rise[gi])
      );
    end
  endgenerate

  assign start_rise = edge_rise[0];
  assign apple_hit  = edge_rise[1];
  // 10 and 11 both count as wall.
  assign wall_hit   = |(collision & WALL_COLLISION);

  assign state = state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      apple_cnt_reg <= '0;
      move_en       <= 1'b0;
      grow          <= 1'b0;
      apple_req     <= 1'b0;
      clear         <= 1'b0;
      game_over     <= 1'b0;
      score         <= '0;
      speed         <= '0;
    end else begin
      // Pulse outputs default low; move_en is re-evaluated every cycle.
      grow    <= 1'b0;
      clear   <= 1'b0;
      move_en <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_rise) begin
            state_reg <= ST_RUN;
            clear     <= 1'b1;
          end
        end
        ST_RUN: begin
          // Wall wins over a simultaneous apple: no grow, no score.
          if (wall_hit) begin
            state_reg <= ST_OVER;
            game_over <= 1'b1;
          end else begin
            move_en <= tick;
            if (apple_hit) begin
              state_reg <= ST_RESPAWN;
              apple_req <= 1'b1;
              grow      <= 1'b1;
              if (score != SCORE_TOP) score <= score + 1'b1;
              if (apple_cnt_reg == CNT_LAST) begin
                apple_cnt_reg <= '0;
                if (speed != SPEED_TOP) speed <= speed + 1'b1;
              end else begin
                apple_cnt_reg <= apple_cnt_reg + 1'b1;
              end
            end
          end
        end
        ST_RESPAWN: begin
          // Apple hits here refer to the stale apple and are dropped.
          if (wall_hit) begin
            state_reg <= ST_OVER;
            game_over <= 1'b1;
            apple_req <= 1'b0;
          end else begin
            move_en <= tick;
            if (apple_ack) begin
              state_reg <= ST_RUN;
              apple_req <= 1'b0;
            end
          end
        end
        ST_OVER: begin
          if (start_rise) begin
            state_reg     <= ST_RUN;
            game_over     <= 1'b0;
            clear         <= 1'b1;
            score         <= '0;
            speed         <= '0;
            apple_cnt_reg <= '0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef SNAKE_HISCORE_EN
  // Score cannot change on the transition into OVER, so the current score
  // is the final score of the game.
  logic enter_over;
  assign enter_over = wall_hit && (state_reg == ST_RUN || state_reg == ST_RESPAWN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             hi_score <= '0;
    else if (enter_over && score > hi_score) hi_score <= score;
  end
`endif

endmodule

// File: tb/tb_snake_game_ctrl.sv
module tb_snake_game_ctrl;

  localparam int SCORE_W       = 8;
  localparam int SPEEDUP_EVERY = 4;
  localparam int SPEED_MAX     = 3;
  localparam int SCORE_MAX     = (1 << SCORE_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               tick = 1'b0;
  logic [1:0]         collision = 2'b00;
  logic               apple_ack = 1'b0;
  logic               move_en, grow, apple_req, clear, game_over;
  logic [1:0]         state;
  logic [SCORE_W-1:0] score;
  logic [1:0]         speed;
`ifdef SNAKE_HISCORE_EN
  logic [SCORE_W-1:0] hi_score;
`endif

  always #5 clk = ~clk;

  snake_game_ctrl #(
    .SCORE_W      (SCORE_W),
    .SPEEDUP_EVERY(SPEEDUP_EVERY),
    .SPEED_MAX    (SPEED_MAX)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .tick     (tick),
    .collision(collision),
    .apple_ack(apple_ack),
    .move_en  (move_en),
    .grow     (grow),
    .apple_req(apple_req),
    .clear    (clear),
    .game_over(game_over),
    .state    (state),
    .score    (score),
    .speed    (speed)
`ifdef SNAKE_HISCORE_EN
    ,
    .hi_score (hi_score)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Game phase as spec'd integer code; score/speed derived from the number
  // of apples eaten this game rather than tracked as counters.
  int m_phase;   // 0 idle, 1 run, 2 respawn, 3 over
  int m_apples;
  int m_hi;
  bit m_start_d, m_apple_d;
  bit m_move, m_grow, m_clear;
  bit model_chk = 1'b0;

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int exp_score();
    return min_i(m_apples, SCORE_MAX);
  endfunction

  function automatic int exp_speed();
    return min_i(m_apples / SPEEDUP_EVERY, SPEED_MAX);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_apples = 0; m_hi = 0;
    m_start_d = 0; m_apple_d = 0;
    m_move = 0; m_grow = 0; m_clear = 0;
  endtask

  task automatic model_step();
    bit s_rise, a_hit, wall;
    s_rise = start && !m_start_d;
    a_hit  = (collision == 2'b01) && !m_apple_d;
    wall   = collision[1];
    m_move = 0; m_grow = 0; m_clear = 0;
    case (m_phase)
      0, 3: if (s_rise) begin m_phase = 1; m_clear = 1; m_apples = 0; end
      1: if (wall) begin
           m_phase = 3; if (exp_score() > m_hi) m_hi = exp_score();
         end else begin
           m_move = tick;
           if (a_hit) begin m_apples++; m_grow = 1; m_phase = 2; end
         end
      default: if (wall) begin
           m_phase = 3; if (exp_score() > m_hi) m_hi = exp_score();
         end else begin
           m_move = tick;
           if (apple_ack) m_phase = 1;
         end
    endcase
    m_start_d = start;
    m_apple_d = (collision == 2'b01);
  endtask

  task automatic compare_model();
    check("mdl_state",     32'(state),     32'(m_phase));
    check("mdl_move_en",   32'(move_en),   32'(m_move));
    check("mdl_grow",      32'(grow),      32'(m_grow));
    check("mdl_clear",     32'(clear),     32'(m_clear));
    check("mdl_apple_req", 32'(apple_req), 32'(m_phase == 2));
    check("mdl_game_over", 32'(game_over), 32'(m_phase == 3));
    check("mdl_score",     32'(score),     32'(exp_score()));
    check("mdl_speed",     32'(speed),     32'(exp_speed()));
`ifdef SNAKE_HISCORE_EN
    check("mdl_hi_score",  32'(hi_score),  32'(m_hi));
`endif
  endtask

  // Inputs are set after a negedge; the model advances at the posedge and
  // outputs are compared at the following negedge.
  task automatic step();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    if (model_chk) compare_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 0; tick = 0; collision = 2'b00; apple_ack = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apple_round();
    collision = 2'b01; step();
    collision = 2'b00; step();
    apple_ack = 1'b1;  step();
    apple_ack = 1'b0;
  endtask

  task automatic play_game(input int n);
    start = 1'b1; step();
    check("game_clear", 32'(clear), 32'd1);
    start = 1'b0;
    for (int k = 0; k < n; k++) apple_round();
    collision = 2'b10; step();
    collision = 2'b00; step();
    check("game_state", 32'(state), 32'd3);
    check("game_score", 32'(score), 32'(n));
    $display("game with %0d apples: state=%0d score=%0d", n, state, score);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       start;
    logic       tick;
    logic [1:0] col;
    logic       ack;
    logic [1:0] st;
    logic       mv, gr, rq, cl, go;
    logic [7:0] sc;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int grows;

    //           start tick col    ack   st    mv gr rq cl go sc
    vecs[0]  = '{1'b0, 1'b1, 2'd1, 1'b1, 2'd0, 0, 0, 0, 0, 0, 8'd0}; // idle ignores all
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd1, 0, 0, 0, 1, 0, 8'd0}; // start edge
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd1, 0, 0, 0, 0, 0, 8'd0};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd1, 0, 0, 0, 0, 0, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 2'd0, 1'b0, 2'd1, 1, 0, 0, 0, 0, 8'd0}; // tick -> move
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd1, 0, 0, 0, 0, 0, 8'd0};
    vecs[6]  = '{1'b0, 1'b0, 2'd1, 1'b0, 2'd2, 0, 1, 1, 0, 0, 8'd1}; // apple
    vecs[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 2'd2, 1, 0, 1, 0, 0, 8'd1}; // held apple
    vecs[8]  = '{1'b0, 1'b0, 2'd1, 1'b1, 2'd1, 0, 0, 0, 0, 0, 8'd1}; // ack
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd1, 0, 0, 0, 0, 0, 8'd1};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 0, 0, 0, 0, 0, 8'd1}; // stray ack
    vecs[11] = '{1'b0, 1'b0, 2'd2, 1'b0, 2'd3, 0, 0, 0, 0, 1, 8'd1}; // wall
    vecs[12] = '{1'b0, 1'b1, 2'd0, 1'b0, 2'd3, 0, 0, 0, 0, 1, 8'd1}; // tick ignored
    vecs[13] = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd1, 0, 0, 0, 1, 0, 8'd0}; // restart
    vecs[14] = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd1, 0, 0, 0, 0, 0, 8'd0};
    vecs[15] = '{1'b0, 1'b0, 2'd3, 1'b0, 2'd3, 0, 0, 0, 0, 1, 8'd0}; // code 11 = wall

    do_reset();
    check("rst_state",     32'(state),     32'd0);
    check("rst_move_en",   32'(move_en),   32'd0);
    check("rst_apple_req", 32'(apple_req), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    check("rst_score",     32'(score),     32'd0);
    check("rst_speed",     32'(speed),     32'd0);

    for (int i = 0; i < 16; i++) begin
      start = vecs[i].start; tick = vecs[i].tick;
      collision = vecs[i].col; apple_ack = vecs[i].ack;
      step();
      check($sformatf("vec%0d_state", i),     32'(state),     32'(vecs[i].st));
      check($sformatf("vec%0d_move_en", i),   32'(move_en),   32'(vecs[i].mv));
      check($sformatf("vec%0d_grow", i),      32'(grow),      32'(vecs[i].gr));
      check($sformatf("vec%0d_apple_req", i), 32'(apple_req), 32'(vecs[i].rq));
      check($sformatf("vec%0d_clear", i),     32'(clear),     32'(vecs[i].cl));
      check($sformatf("vec%0d_game_over", i), 32'(game_over), 32'(vecs[i].go));
      check($sformatf("vec%0d_score", i),     32'(score),     32'(vecs[i].sc));
      $display("vec %0d: st=%0d mv=%0d gr=%0d rq=%0d cl=%0d go=%0d sc=%0d",
               i, state, move_en, grow, apple_req, clear, game_over, score);
    end
    start = 0; tick = 0; collision = 2'b00; apple_ack = 0;

    // From here on the model checks every cycle as well.
    model_chk = 1'b1;
    step();

    // Held apple code: one grow only, then ack ten cycles later.
    start = 1'b1; step();
    check("seq1_clear", 32'(clear), 32'd1);
    start = 1'b0;
    grows = 0;
    collision = 2'b01;
    for (int i = 0; i < 20; i++) begin step(); grows += int'(grow); end
    collision = 2'b00;
    check("seq1_grows",     32'(grows),     32'd1);
    check("seq1_score",     32'(score),     32'd1);
    check("seq1_state",     32'(state),     32'd2);
    check("seq1_apple_req", 32'(apple_req), 32'd1);
    repeat (9) step();
    apple_ack = 1'b1; step(); apple_ack = 1'b0;
    check("seq1_ack_state", 32'(state),     32'd1);
    check("seq1_ack_req",   32'(apple_req), 32'd0);
    $display("held apple: grows=%0d score=%0d state=%0d", grows, score, state);

    // Speed-up and saturation.
    for (int n = 2; n <= 260; n++) begin
      apple_round();
      if (n == 4)   begin check("spd_at4_score", 32'(score), 32'd4); check("spd_at4", 32'(speed), 32'd1); end
      if (n == 16)  check("spd_at16", 32'(speed), 32'd3);
      if (n == 20)  begin check("spd_at20", 32'(speed), 32'd3); check("score_at20", 32'(score), 32'd20); end
      if (n == 260) check("score_sat", 32'(score), 32'(SCORE_MAX));
      if (n % 20 == 0) $display("apples=%0d score=%0d speed=%0d", n, score, speed);
    end

    // Wall in RESPAWN with a simultaneous ack.
    collision = 2'b01; step();
    collision = 2'b10; apple_ack = 1'b1; step();
    check("wallack_state",     32'(state),     32'd3);
    check("wallack_game_over", 32'(game_over), 32'd1);
    check("wallack_apple_req", 32'(apple_req), 32'd0);
    check("wallack_grow",      32'(grow),      32'd0);
    collision = 2'b00; apple_ack = 1'b0; step();
    start = 1'b1; step(); start = 1'b0;
    check("restart_state", 32'(state), 32'd1);
    check("restart_clear", 32'(clear), 32'd1);
    check("restart_score", 32'(score), 32'd0);
    check("restart_speed", 32'(speed), 32'd0);
    $display("wall+ack: restarted state=%0d score=%0d", state, score);

    // Asynchronous reset in the middle of RESPAWN.
    collision = 2'b01; step();
    check("pre_rst_state", 32'(state), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state",     32'(state),     32'd0);
    check("arst_apple_req", 32'(apple_req), 32'd0);
    check("arst_score",     32'(score),     32'd0);
    check("arst_speed",     32'(speed),     32'd0);
    check("arst_game_over", 32'(game_over), 32'd0);
`ifdef SNAKE_HISCORE_EN
    check("arst_hi_score",  32'(hi_score),  32'd0);
`endif
    model_reset();
    collision = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    $display("async reset: state=%0d score=%0d", state, score);

    // Two games: 5 then 3 apples.
    play_game(5);
    play_game(3);
`ifdef SNAKE_HISCORE_EN
    check("hi_after_2games", 32'(hi_score), 32'd5);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      start     = ($urandom_range(0, 9) == 0);
      tick      = ($urandom_range(0, 2) == 0);
      apple_ack = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 19);
      collision = (r < 14) ? 2'b00 : (r < 18) ? 2'b01 : (r == 18) ? 2'b10 : 2'b11;
      step();
    end
    $display("random phase: %0d cycles, state=%0d score=%0d", 3000, state, score);

    do_reset();
    check("final_rst_state", 32'(state), 32'd0);
`ifdef SNAKE_HISCORE_EN
    check("final_rst_hi", 32'(hi_score), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
